// File: rtl/dmem_responder.sv
// Word-addressed SRAM responder with valid/ready request/response handshake and fixed access latency.
// Optional macro DMEM_STALL_INJECT_EN adds 0..3 LFSR-driven extra wait cycles per request.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | access latency countdown
    // RESP  | response presented until accepted
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt, load_cnt;
    logic [1:0]  extra;
    logic        accept, commit;

    logic [31:0] lat_addr, lat_wdata;
    logic        lat_ren, lat_wen;
    logic [3:0]  lat_mask;

    logic [31:0] cur_addr, cur_wdata;
    logic        cur_ren, cur_wen;
    logic [3:0]  cur_mask;

    logic [31:0] off;
    logic        in_range, fault;
    logic [IDX_W-1:0] idx;
    logic [31:0] lane_bits;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        fault_q;

    assign accept = i_req_valid && (state == IDLE);

`ifdef DMEM_STALL_INJECT_EN
    // The current LFSR value sets this request's stall; the register then advances.
    logic [7:0] lfsr;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            lfsr <= 8'hA5;
        else if (accept)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign extra = lfsr[1:0];
`else
    assign extra = 2'd0;
`endif

    assign load_cnt = 5'(LATENCY - 1) + 5'(extra);

    // With a zero countdown the access commits on the accept edge, so decode the live request.
    assign cur_addr  = (state == IDLE) ? i_req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? i_req_wdata : lat_wdata;
    assign cur_ren   = (state == IDLE) ? i_req_ren   : lat_ren;
    assign cur_wen   = (state == IDLE) ? i_req_wen   : lat_wen;
    assign cur_mask  = (state == IDLE) ? i_req_mask  : lat_mask;

    assign off       = cur_addr - BASE_ADDR;
    assign in_range  = {1'b0, off} < SPAN;
    assign idx       = off[IDX_W+1:2];
    assign fault     = (cur_ren == cur_wen) || (cur_addr[1:0] != 2'b00) ||
                       (cur_mask == 4'b0000) || !in_range;
    assign lane_bits = {{8{cur_mask[3]}}, {8{cur_mask[2]}}, {8{cur_mask[1]}}, {8{cur_mask[0]}}};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    if (load_cnt == 5'd0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = load_cnt;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 5'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 5'd0;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
            RESP: begin
                if (i_rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_ren   <= 1'b0;
            lat_wen   <= 1'b0;
            lat_mask  <= 4'd0;
            rdata_q   <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_addr  <= i_req_addr;
                lat_wdata <= i_req_wdata;
                lat_ren   <= i_req_ren;
                lat_wen   <= i_req_wen;
                lat_mask  <= i_req_mask;
            end
            if (commit) begin
                fault_q <= fault;
                rdata_q <= (!fault && cur_ren) ? (mem[idx] & lane_bits) : 32'd0;
            end
        end
    end

    // Array is never cleared; reset gating keeps a dropped write out of memory.
    always_ff @(posedge i_clk) begin
        if (commit && i_rst_n && cur_wen && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_mask[b])
                    mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_fault = fault_q;

endmodule
